// File: rtl/vx_cache_wb_pkg.sv
// Shared types and width helpers for the write-back cache bank data store.
// Default geometry matches the standard bank configuration.
package vx_cache_wb_pkg;

   function automatic int calc_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_CACHE_SIZE = 16384;
   localparam int DEF_LINE_SIZE  = 64;
   localparam int DEF_WORD_SIZE  = 4;
   localparam int DEF_NUM_BANKS  = 1;

   localparam int WPL   = DEF_LINE_SIZE / DEF_WORD_SIZE;
   localparam int LINES = DEF_CACHE_SIZE / (DEF_LINE_SIZE * DEF_NUM_BANKS);
   localparam int LSB   = calc_bits(LINES);
   localparam int WSB   = calc_bits(WPL);

   typedef enum logic [1:0] {
      FL_IDLE    = 2'd0,
      FL_SCAN    = 2'd1,
      FL_CAPTURE = 2'd2,
      FL_DONE    = 2'd3
   } flush_state_e;

   typedef struct packed {
      logic [LSB-1:0]             line;
      logic [DEF_LINE_SIZE*8-1:0] data;
   } evict_t;

endpackage

// File: rtl/vx_dirty_flush_ctrl.sv
// Per-line dirty tracking plus the flush walker that visits every line
// and hands dirty ones to the evict buffer.
module vx_dirty_flush_ctrl
   import vx_cache_wb_pkg::*;
#(
   parameter int LINES        = 256,
   parameter int LSB          = 8,
   parameter int WRITE_ENABLE = 1,
   parameter int WRITEBACK    = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           stall,
   input  logic           flush_req,
   input  logic           op_acc,
   input  logic           write_acc,
   input  logic           fill_acc,
   input  logic [LSB-1:0] addr,
   input  logic           evict_valid,
   input  logic           evict_ready,
   output logic           idle,
   output logic           fill_dirty,
   output logic           scan_rd,
   output logic           capture,
   output logic [LSB-1:0] idx_line,
   output logic           flush_busy,
   output logic           flush_done
);

   flush_state_e     state, state_n;
   logic [LSB:0]     idx, idx_n;
   logic [LINES-1:0] dirty;
   logic             last;
   logic             idx_dirty;
   logic             buf_free;

   assign idx_line   = idx[LSB-1:0];
   assign last       = (idx == (LSB+1)'(LINES-1));
   assign idx_dirty  = dirty[idx_line];
   assign fill_dirty = dirty[addr];
   assign buf_free   = !evict_valid || evict_ready;

   assign idle       = (state == FL_IDLE);
   assign flush_busy = !idle;
   assign flush_done = (state == FL_DONE);

   always_comb begin
      state_n = state;
      idx_n   = idx;
      scan_rd = 1'b0;
      capture = 1'b0;
      if (!stall) begin
         unique case (state)
            FL_IDLE: begin
               if (flush_req && !op_acc) begin
                  idx_n   = '0;
                  state_n = (WRITE_ENABLE != 0) ? FL_SCAN : FL_DONE;
               end
            end
            FL_SCAN: begin
               if (idx_dirty) begin
                  if (buf_free) begin
                     scan_rd = 1'b1;
                     state_n = FL_CAPTURE;
                  end
               end else if (last) begin
                  state_n = FL_DONE;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
            FL_CAPTURE: begin
               capture = 1'b1;
               if (last) begin
                  state_n = FL_DONE;
               end else begin
                  idx_n   = idx + 1'b1;
                  state_n = FL_SCAN;
               end
            end
            FL_DONE: state_n = FL_IDLE;
            default: state_n = FL_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FL_IDLE;
         idx   <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
      end
   end

   // Ops only run in IDLE, so fill/write never collide with a capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dirty <= '0;
      end else begin
         if (write_acc && (WRITEBACK != 0))
            dirty[addr] <= 1'b1;
         if (fill_acc)
            dirty[addr] <= 1'b0;
         if (capture)
            dirty[idx_line] <= 1'b0;
      end
   end

endmodule

// File: rtl/vx_data_access_wb.sv
// Bank line store with dirty tracking, a one-entry evict buffer and a
// flush walker; sits between tag access and response/memory request.
module vx_data_access_wb
   import vx_cache_wb_pkg::*;
#(
   parameter  int CACHE_SIZE      = 16384,
   parameter  int CACHE_LINE_SIZE = 64,
   parameter  int NUM_BANKS       = 1,
   parameter  int NUM_PORTS       = 1,
   parameter  int WORD_SIZE       = 4,
   parameter  int WRITE_ENABLE    = 1,
   parameter  int WRITEBACK       = 1,
   localparam int WPL_P   = CACHE_LINE_SIZE / WORD_SIZE,
   localparam int LINES_P = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS),
   localparam int LSB_P   = calc_bits(LINES_P),
   localparam int WSB_P   = calc_bits(WPL_P),
   localparam int WBITS   = WORD_SIZE * 8,
   localparam int LBITS   = CACHE_LINE_SIZE * 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   output logic                         ready,
   input  logic                         read,
   input  logic                         write,
   input  logic                         fill,
   input  logic [LSB_P-1:0]             addr,
   input  logic [NUM_PORTS*WSB_P-1:0]   wsel,
   input  logic [NUM_PORTS-1:0]         pmask,
   input  logic [NUM_PORTS*WORD_SIZE-1:0] byteen,
   input  logic [NUM_PORTS*WBITS-1:0]   write_data,
   input  logic [LBITS-1:0]             fill_data,
   output logic [NUM_PORTS*WBITS-1:0]   read_data,
   output logic                         rsp_valid,
   output logic                         evict_valid,
   input  logic                         evict_ready,
   output logic [LSB_P-1:0]             evict_line,
   output logic [LBITS-1:0]             evict_data,
   input  logic                         flush_req,
   output logic                         flush_busy,
   output logic                         flush_done
);

   typedef struct packed {
      logic [LSB_P-1:0] line;
      logic [LBITS-1:0] data;
   } evict_rec_t;

   logic idle, fill_dirty, scan_rd, capture;
   logic [LSB_P-1:0] idx_line;

   logic wr_req, op_req, op_acc;
   logic read_acc, write_acc, fill_acc;
   logic load_fill;

   logic                       ram_en;
   logic [LSB_P-1:0]           ram_addr;
   logic [CACHE_LINE_SIZE-1:0] ram_wren;
   logic [LBITS-1:0]           ram_wdata;
   logic [LBITS-1:0]           ram_rdata;
   logic [LBITS-1:0]           mem [LINES_P];

   logic [NUM_PORTS*WSB_P-1:0] wsel_q;
   logic                       evict_fresh;
   evict_rec_t                 evict_q;

   assign wr_req    = write && (WRITE_ENABLE != 0);
   assign op_req    = read || wr_req || fill;
   assign ready     = idle && !(fill && evict_valid && !evict_ready);
   assign op_acc    = op_req && ready && !stall;
   assign read_acc  = op_acc && read;
   assign write_acc = op_acc && wr_req;
   assign fill_acc  = op_acc && fill;
   assign load_fill = fill_acc && fill_dirty;

   vx_dirty_flush_ctrl #(
      .LINES        (LINES_P),
      .LSB          (LSB_P),
      .WRITE_ENABLE (WRITE_ENABLE),
      .WRITEBACK    (WRITEBACK)
   ) u_ctrl (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush_req   (flush_req),
      .op_acc      (op_acc),
      .write_acc   (write_acc),
      .fill_acc    (fill_acc),
      .addr        (addr),
      .evict_valid (evict_valid),
      .evict_ready (evict_ready),
      .idle        (idle),
      .fill_dirty  (fill_dirty),
      .scan_rd     (scan_rd),
      .capture     (capture),
      .idx_line    (idx_line),
      .flush_busy  (flush_busy),
      .flush_done  (flush_done)
   );

   assign ram_en   = op_acc || scan_rd;
   assign ram_addr = scan_rd ? idx_line : addr;

   always_comb begin
      ram_wren  = '0;
      ram_wdata = '0;
      unique case (1'b1)
         fill_acc: begin
            ram_wren  = '1;
            ram_wdata = fill_data;
         end
         write_acc: begin
            // Ascending port order: a higher port overwrites shared bytes.
            for (int i = 0; i < NUM_PORTS; i++) begin
               for (int b = 0; b < WORD_SIZE; b++) begin
                  if (pmask[i] && byteen[i*WORD_SIZE+b]) begin
                     ram_wren[int'(wsel[i*WSB_P +: WSB_P])*WORD_SIZE+b]
                        = 1'b1;
                     ram_wdata[(int'(wsel[i*WSB_P +: WSB_P])*WORD_SIZE+b)*8
                        +: 8] = write_data[(i*WORD_SIZE+b)*8 +: 8];
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // Single-port, read-first line RAM with per-byte write enable.
   always_ff @(posedge clk) begin
      if (ram_en) begin
         ram_rdata <= mem[ram_addr];
         for (int b = 0; b < CACHE_LINE_SIZE; b++) begin
            if (ram_wren[b])
               mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rsp_valid <= 1'b0;
      else if (!stall)
         rsp_valid <= read_acc;
   end

   always_ff @(posedge clk) begin
      if (read_acc)
         wsel_q <= wsel;
   end

   always_comb begin
      read_data = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         read_data[i*WBITS +: WBITS] =
            ram_rdata[int'(wsel_q[i*WSB_P +: WSB_P])*WBITS +: WBITS];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         evict_valid <= 1'b0;
         evict_fresh <= 1'b0;
      end else begin
         evict_fresh <= load_fill;
         if (load_fill || capture)
            evict_valid <= 1'b1;
         else if (evict_ready)
            evict_valid <= 1'b0;
      end
   end

   // A fill victim is presented straight from the RAM output register
   // for its first cycle, then latched so it stays put until taken.
   always_ff @(posedge clk) begin
      if (load_fill)
         evict_q.line <= addr;
      else if (capture)
         evict_q.line <= idx_line;
      if (capture || evict_fresh)
         evict_q.data <= ram_rdata;
   end

   assign evict_line = evict_q.line;
   assign evict_data = evict_fresh ? ram_rdata : evict_q.data;

endmodule
